// File: rtl/dds_pkg.sv
// Shared constants and elaboration-time helpers for the DDS numerically
// controlled oscillator.
package dds_pkg;

    // Table organisation selected by the MODE parameter.
    localparam int MODE_FULL    = 0;
    localparam int MODE_QUARTER = 1;

    // Checks whether a MODE/width combination can be built. Quarter-wave
    // addressing needs two extra phase bits above the table index for the
    // quadrant. Full-wave addressing only needs the index bits.
    function automatic bit widths_ok(input int mode, input int phase_w, input int addr_w);
        if (mode == MODE_QUARTER)
            return (phase_w >= addr_w + 2);
        else if (mode == MODE_FULL)
            return (phase_w >= addr_w);
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/dds_nco_if.sv
// Waveform-table write port. The table loader is the master and the NCO
// is the slave.
interface dds_nco_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic                     tbl_we;
    logic [ADDR_W-1:0]        tbl_addr;
    logic signed [DATA_W-1:0] tbl_wdata;

    modport master (output tbl_we, output tbl_addr, output tbl_wdata);
    modport slave  (input  tbl_we, input  tbl_addr, input  tbl_wdata);
endinterface

// File: rtl/dds_phase_acc.sv
// Phase accumulator for one NCO channel. A preload overrides the advance.
// acc_next is exported so that the lookup pipeline can use the
// post-update phase at the same edge.
module dds_phase_acc #(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               en,
    input  logic               updn,
    input  logic               preload,
    input  logic [PHASE_W-1:0] pl_phase,
    input  logic [PHASE_W-1:0] fword,
    output logic [PHASE_W-1:0] acc,
    output logic [PHASE_W-1:0] acc_next
);
    logic [PHASE_W-1:0] acc_reg;

    // Next phase: preload wins. Otherwise the accumulator advances with a
    // modular add or subtract.
    always_comb begin
        acc_next = acc_reg;
        if (preload)
            acc_next = pl_phase;
        else if (tick && en)
            acc_next = updn ? (acc_reg + fword) : (acc_reg - fword);
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_reg <= '0;
        else
            acc_reg <= acc_next;
    end

    assign acc = acc_reg;
endmodule

// File: rtl/dds_nco.sv
// Multi-channel DDS NCO. It has per-channel phase accumulators and one shared
// waveform table with one read port per channel. Lookup is a two-stage
// pipeline. Stage 1 registers the table index and quadrant. Stage 2
// registers the sample.
module dds_nco
    import dds_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int NCH     = 2,
    parameter int MODE    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH-1:0]         updn,
    input  logic [NCH-1:0]         preload,
    input  logic [NCH*PHASE_W-1:0] pl_phase,
    input  logic [NCH*PHASE_W-1:0] fword,
    input  logic [NCH*PHASE_W-1:0] poff,
    dds_nco_if.slave               tbl,
    output logic [NCH*PHASE_W-1:0] phase_out,
    output logic [NCH*DATA_W-1:0]  wave_out,
    output logic                   wave_valid
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    generate
        if (!widths_ok(MODE, PHASE_W, ADDR_W)) begin : g_bad_widths
            $error("dds_nco: illegal MODE/PHASE_W/ADDR_W combination");
        end
    endgenerate

    // The table is not reset. Its contents survive a reset.
    logic signed [DATA_W-1:0] tbl_mem [DEPTH];
    logic                     valid1_reg;

    // Table write port. A read of the same address at this edge still sees
    // the old word.
    always_ff @(posedge clk) begin
        if (tbl.tbl_we)
            tbl_mem[tbl.tbl_addr] <= tbl.tbl_wdata;
    end

    // Pipeline valid. A reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1_reg <= 1'b0;
            wave_valid <= 1'b0;
        end else begin
            valid1_reg <= tick;
            wave_valid <= valid1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PHASE_W-1:0]       acc;
            logic [PHASE_W-1:0]       acc_next;
            logic [PHASE_W-1:0]       p;
            logic [ADDR_W-1:0]        idx;
            logic                     neg;
            logic [ADDR_W-1:0]        addr_reg;
            logic                     neg_reg;
            logic signed [DATA_W-1:0] rd;
            logic signed [DATA_W-1:0] smp;
            logic signed [DATA_W-1:0] wave_reg;

            dds_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
                .clk      (clk),
                .reset    (reset),
                .tick     (tick),
                .en       (ch_en[gi]),
                .updn     (updn[gi]),
                .preload  (preload[gi]),
                .pl_phase (pl_phase[gi*PHASE_W +: PHASE_W]),
                .fword    (fword[gi*PHASE_W +: PHASE_W]),
                .acc      (acc),
                .acc_next (acc_next)
            );

            assign phase_out[gi*PHASE_W +: PHASE_W] = acc;
            // The offset changes only the lookup phase, not the accumulator.
            assign p = acc_next + poff[gi*PHASE_W +: PHASE_W];

            if (MODE == MODE_QUARTER) begin : g_quarter
                logic [1:0]        q;
                logic [ADDR_W-1:0] raw;
                assign q   = p[PHASE_W-1 -: 2];
                assign raw = p[PHASE_W-3 -: ADDR_W];
                // Odd quadrants walk the quarter table backwards. The upper
                // half-cycle is negated.
                assign idx = q[0] ? ~raw : raw;
                assign neg = q[1];
            end else begin : g_full
                assign idx = p[PHASE_W-1 -: ADDR_W];
                assign neg = 1'b0;
            end

            // Stage 1: capture the table index and sign for this tick.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    addr_reg <= '0;
                    neg_reg  <= 1'b0;
                end else if (tick) begin
                    addr_reg <= idx;
                    neg_reg  <= neg;
                end
            end

            // Table read and symmetry reconstruction. Negating the most
            // negative value saturates instead of wrapping.
            always_comb begin
                rd  = tbl_mem[addr_reg];
                smp = rd;
                if (neg_reg)
                    smp = (rd == S_MIN) ? S_MAX : -rd;
            end

            // Stage 2: register the sample.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    wave_reg <= '0;
                else if (valid1_reg)
                    wave_reg <= smp;
            end

            assign wave_out[gi*DATA_W +: DATA_W] = wave_reg;
        end
    endgenerate
endmodule

// File: tb/tb_dds_nco.sv
// Directed bench for dds_nco. dut0 is a two-channel full-wave instance.
// dut1 is a one-channel quarter-wave instance with a 64-entry table.
module tb_dds_nco;
    logic clk;
    logic reset;

    logic        tick0;
    logic [1:0]  ch_en0, updn0, preload0;
    logic [31:0] pl0, fw0, po0;
    logic [31:0] phase0, wave0;
    logic        valid0;

    logic        tick1;
    logic [0:0]  ch_en1, updn1, preload1;
    logic [15:0] pl1, fw1, po1;
    logic [15:0] phase1, wave1;
    logic        valid1;

    int tests;
    int failed;

    dds_nco_if #(.ADDR_W(8), .DATA_W(16)) tif0 ();
    dds_nco_if #(.ADDR_W(6), .DATA_W(16)) tif1 ();

    dds_nco #(.PHASE_W(16), .ADDR_W(8), .DATA_W(16), .NCH(2), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick0), .ch_en(ch_en0), .updn(updn0),
        .preload(preload0), .pl_phase(pl0), .fword(fw0), .poff(po0), .tbl(tif0),
        .phase_out(phase0), .wave_out(wave0), .wave_valid(valid0)
    );

    dds_nco #(.PHASE_W(16), .ADDR_W(6), .DATA_W(16), .NCH(1), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick1), .ch_en(ch_en1), .updn(updn1),
        .preload(preload1), .pl_phase(pl1), .fword(fw1), .poff(po1), .tbl(tif1),
        .phase_out(phase1), .wave_out(wave1), .wave_valid(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] %s ok obs=0x%0h", tag, obs);
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        reset = 1'b1;
        tick0 = 0; ch_en0 = 0; updn0 = 0; preload0 = 0; pl0 = 0; fw0 = 0; po0 = 0;
        tick1 = 0; ch_en1 = 0; updn1 = 0; preload1 = 0; pl1 = 0; fw1 = 0; po1 = 0;
        tif0.tbl_we = 0; tif0.tbl_addr = 0; tif0.tbl_wdata = 0;
        tif1.tbl_we = 0; tif1.tbl_addr = 0; tif1.tbl_wdata = 0;
        #2;
        check("rst_phase0", phase0, 32'h0);
        check("rst_wave0", wave0, 32'h0);
        check("rst_valid0", {31'b0, valid0}, 32'h0);
        @(negedge clk);
        step();
        reset = 1'b0;

        // Table loads: dut0 gets table[k] = k*256 and dut1 gets table[j] = j+1.
        for (int k = 0; k < 256; k++) begin
            tif0.tbl_we = 1'b1; tif0.tbl_addr = k[7:0]; tif0.tbl_wdata = 16'(k * 256);
            tif1.tbl_we = (k < 64); tif1.tbl_addr = k[5:0]; tif1.tbl_wdata = 16'(k + 1);
            step();
        end
        tif0.tbl_we = 0; tif1.tbl_we = 0;

        // Ramp test on ch0: three back-to-back ticks.
        ch_en0 = 2'b01; updn0 = 2'b11; fw0 = 32'h0100_0100;
        tick0 = 1; step();
        check("ramp_phase_t1", {16'h0, phase0[15:0]}, 32'h0100);
        check("ramp_valid_t1", {31'b0, valid0}, 32'h0);
        step();
        check("ramp_wave_1", {16'h0, wave0[15:0]}, 32'h0100);
        check("ramp_valid_1", {31'b0, valid0}, 32'h1);
        step();
        check("ramp_wave_2", {16'h0, wave0[15:0]}, 32'h0200);
        tick0 = 0; step();
        check("ramp_wave_3", {16'h0, wave0[15:0]}, 32'h0300);
        check("ramp_valid_3", {31'b0, valid0}, 32'h1);
        check("ramp_ch1_idle", {16'h0, phase0[31:16]}, 32'h0);
        step();
        check("ramp_valid_end", {31'b0, valid0}, 32'h0);

        // Wrap test, counting up on ch1.
        preload0 = 2'b10; pl0 = 32'hFF80_0000; step();
        check("wrap_preload", {16'h0, phase0[31:16]}, 32'hFF80);
        preload0 = 0; ch_en0 = 2'b10; tick0 = 1; step();
        check("wrap_up_phase", {16'h0, phase0[31:16]}, 32'h0080);
        tick0 = 0; step();
        check("wrap_up_wave1", {16'h0, wave0[31:16]}, 32'h0000);
        check("wrap_disabled_ch0", {16'h0, wave0[15:0]}, 32'h0300);

        // Wrap test, counting down on ch1.
        preload0 = 2'b10; pl0 = 32'h0; step();
        preload0 = 0; updn0 = 2'b01; tick0 = 1; step();
        check("wrap_dn_phase", {16'h0, phase0[31:16]}, 32'hFF00);
        tick0 = 0; step();
        check("wrap_dn_wave1", {16'h0, wave0[31:16]}, 32'hFF00);

        // Phase offset applied at lookup only.
        ch_en0 = 0; preload0 = 2'b01; pl0 = 32'h0000_0100; step();
        preload0 = 0; po0 = 32'h0000_8000; tick0 = 1; step();
        check("poff_acc_kept", {16'h0, phase0[15:0]}, 32'h0100);
        tick0 = 0; step();
        check("poff_wave0", {16'h0, wave0[15:0]}, 32'h8100);
        po0 = 0;

        // Preload and tick together: the preload wins.
        preload0 = 2'b01; pl0 = 32'h0000_2000; ch_en0 = 2'b01; updn0 = 2'b11;
        tick0 = 1; step();
        check("prio_phase", {16'h0, phase0[15:0]}, 32'h2000);
        preload0 = 0; tick0 = 0; ch_en0 = 0; step();
        check("prio_wave", {16'h0, wave0[15:0]}, 32'h2000);

        // Collision: write the address being read at the same edge.
        tick0 = 1; step();
        tick0 = 0;
        tif0.tbl_we = 1; tif0.tbl_addr = 8'h20; tif0.tbl_wdata = 16'h1234; step();
        check("coll_old_data", {16'h0, wave0[15:0]}, 32'h2000);
        tif0.tbl_we = 0; tick0 = 1; step();
        tick0 = 0; step();
        check("coll_new_data", {16'h0, wave0[15:0]}, 32'h1234);

        // Reset mid-stream while a lookup is in flight.
        tick0 = 1; step();
        tick0 = 0; reset = 1; #1;
        check("mid_rst_wave", wave0, 32'h0);
        check("mid_rst_phase", phase0, 32'h0);
        check("mid_rst_valid", {31'b0, valid0}, 32'h0);
        @(negedge clk);
        reset = 0; step();
        check("post_rst_novalid1", {31'b0, valid0}, 32'h0);
        step();
        check("post_rst_novalid2", {31'b0, valid0}, 32'h0);
        preload0 = 2'b01; pl0 = 32'h0000_2000; step();
        preload0 = 0; tick0 = 1; step();
        tick0 = 0; step();
        check("post_rst_valid", {31'b0, valid0}, 32'h1);
        check("tbl_kept_on_rst", {16'h0, wave0[15:0]}, 32'h1234);

        // Quarter-wave instance.
        preload1 = 1; pl1 = 16'h4000; step();
        preload1 = 0; tick1 = 1; step();
        tick1 = 0; step();
        check("qw_q1", {16'h0, wave1}, 32'h0040);
        check("qw_valid", {31'b0, valid1}, 32'h1);
        preload1 = 1; pl1 = 16'h8100; step();
        preload1 = 0; tick1 = 1; step();
        tick1 = 0; step();
        check("qw_q2_neg", {16'h0, wave1}, 32'hFFFE);
        tif1.tbl_we = 1; tif1.tbl_addr = 6'd0; tif1.tbl_wdata = 16'h8000; step();
        tif1.tbl_we = 0; preload1 = 1; pl1 = 16'h8000; step();
        preload1 = 0; tick1 = 1; step();
        tick1 = 0; step();
        check("qw_saturate", {16'h0, wave1}, 32'h7FFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/dds_nco.md
DDS_NCO -- requirements
Module: dds_nco

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, meaning phase accumulator width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the waveform table holds 2^ADDR_W entries.
REQ-003 SHALL have parameter DATA_W, default 16, meaning signed sample width.
REQ-004 SHALL have parameter NCH, default 2, meaning number of independent channels.
REQ-005 SHALL have parameter MODE, default 0, meaning 0 = full-wave table, 1 = quarter-wave table with symmetry reconstruction.
REQ-006 SHALL have port clk  input  1  clock, all logic on the rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port tick  input  1  sample strobe; advances all enabled channels.
REQ-009 SHALL have port ch_en  input  NCH  per-channel accumulate enable.
REQ-010 SHALL have port updn  input  NCH  per-channel direction: 1 = add, 0 = subtract.
REQ-011 SHALL have port preload  input  NCH  per-channel accumulator load strobe.
REQ-012 SHALL have port pl_phase  input  NCH*PHASE_W  preload values; channel c occupies slice c.
REQ-013 SHALL have port fword  input  NCH*PHASE_W  frequency (increment) words.
REQ-014 SHALL have port poff  input  NCH*PHASE_W  phase offsets, added at lookup only.
REQ-015 SHALL have port tbl_we  input  1  table write strobe.
REQ-016 SHALL have port tbl_addr  input  ADDR_W  table write address.
REQ-017 SHALL have port tbl_wdata  input  DATA_W  table write data, signed.
REQ-018 SHALL have port phase_out  output  NCH*PHASE_W  current accumulator values.
REQ-019 SHALL have port wave_out  output  NCH*DATA_W  registered samples.
REQ-020 SHALL have port wave_valid  output  1  one-cycle pulse marking new wave_out.

Function
REQ-021 SHALL advance each channel at the edge where tick=1 and ch_en[c]=1: acc = acc ± fword, modulo 2^PHASE_W (wraps silently both ways).
REQ-022 SHALL give preload[c] priority over advance; the loaded value is pl_phase[c]; preload acts without tick.
REQ-023 SHALL launch a lookup for all channels on every tick edge, using the post-update accumulators, whether or not each channel is enabled.
REQ-024 SHALL form lookup phase p = acc + poff (mod 2^PHASE_W) in stage 1, registering the index and quadrant.
REQ-025 SHALL in MODE 0 use index = p[PHASE_W-1 -: ADDR_W], and set sample = table[index].
REQ-026 SHALL in MODE 1 use q = p[PHASE_W-1 -: 2], raw = p[PHASE_W-3 -: ADDR_W] and addr = q[0] ? ~raw : raw; sample = q[1] ? -table[addr] : table[addr], with the most-negative value saturating to the most-positive value.
REQ-027 SHALL register the sample in stage 2: wave_out and wave_valid appear 2 edges after the tick edge; back-to-back ticks give back-to-back valid pulses.
REQ-028 SHALL write table[tbl_addr] = tbl_wdata at the edge where tbl_we=1; a read of the same address in that cycle returns the old data.
REQ-029 SHALL require PHASE_W >= ADDR_W+2 when MODE=1 and PHASE_W >= ADDR_W otherwise; an illegal combination shall be an elaboration error.

Reset
REQ-030 SHALL clear accumulators, pipeline registers, phase_out, wave_out and wave_valid to 0 asynchronously while reset=1.
REQ-031 SHALL leave table contents unaffected by reset.
REQ-032 SHALL discard any in-flight lookup on reset mid-stream, so that no wave_valid is produced for ticks issued before reset.

Structure
REQ-033 SHALL place the MODE encodings (MODE_FULL = 0, MODE_QUARTER = 1) and the width legality checks in package dds_pkg.
REQ-034 SHALL implement the per-channel accumulator (REQ-021/022) as sub-module dds_phase_acc, instantiated NCH times; the table is a single shared register array with NCH read ports.

Verification (defaults unless stated)
REQ-035 SHALL cover reset: assert reset mid-stream -> all outputs 0 at once, no valid pulse afterwards until a new tick.
REQ-036 SHALL cover ramp: load table[k] = k*256, fword0 = 0x0100, updn = 1, tick for 3 cycles -> wave_out ch0 = 0x0100, 0x0200, 0x0300, each 2 edges after its tick.
REQ-037 SHALL cover wrap: preload ch1 = 0xFF80, fword = 0x0100, one tick -> phase_out ch1 = 0x0080, sample = table[0]; with updn = 0 from 0 -> 0xFF00, sample = table[255].
REQ-038 SHALL cover offset/priority: poff0 = 0x8000 at acc = 0x0100 -> sample = table[129]; preload and tick together -> the preloaded value is used.
REQ-039 SHALL cover quarter mode: MODE = 1, ADDR_W = 6, table[j] = j+1 -> p = 0x4000 gives 0x0040, p = 0x8100 gives 0xFFFE; table entry 0x8000 in quadrant 2 gives 0x7FFF.
REQ-040 SHALL cover write/read collision: tbl_we to the address being looked up in the same cycle -> old data out, new data on the next tick.
